// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single register-file write port and shares it
// between ALU writeback and load writeback using valid/ready handshakes.
// After reset it zeroes x1..x(NREGS-1) before serving any requester.
// Optional macro RR_ARB_EN: resolve conflicts round-robin instead of the
// default mem-first priority with an ALU starvation guard.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int STARVE_MAX = 4,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            we,
  output logic [AW-1:0]   wrAddr,
  output logic [XLEN-1:0] wrData,
  output logic            busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            conflict;
  logic            alu_pri;
  logic            alu_fire;
  logic            mem_fire;

`ifdef RR_ARB_EN
  // 0 = ALU wins the next conflict, 1 = mem wins it.
  logic rr_q, rr_d;
`else
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0] starve_q, starve_d;
`endif

  // Grant decision: ready is combinational from valid and state, one-hot at most.
  always_comb begin
    conflict  = (state_q == RUN) && alu_valid && mem_valid;
`ifdef RR_ARB_EN
    alu_pri   = ~rr_q;
`else
    alu_pri   = (starve_q == SW'(STARVE_MAX));
`endif
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (state_q == RUN) begin
      if (conflict) begin
        alu_ready = alu_pri;
        mem_ready = ~alu_pri;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;

  // Next-state: clear sequencing, write-port staging and arbitration history.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = (state_q == CLEAR);
`ifdef RR_ARB_EN
    rr_d    = rr_q;
`else
    starve_d = starve_q;
`endif
    case (state_q)
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
      end
      RUN: begin
        // rd==0 is accepted but discarded; the port keeps its last address/data.
        if (alu_fire) begin
          if (alu_rd != '0) begin
            we_d   = 1'b1;
            addr_d = alu_rd;
            data_d = alu_data;
          end
        end else if (mem_fire) begin
          if (mem_rd != '0) begin
            we_d   = 1'b1;
            addr_d = mem_rd;
            data_d = mem_data;
          end
        end
`ifdef RR_ARB_EN
        if (conflict) rr_d = ~rr_q;
`else
        if (alu_fire)      starve_d = '0;
        else if (conflict) starve_d = starve_q + SW'(1);
`endif
      end
      default: state_d = CLEAR;
    endcase
  end

  // State register; reset restarts the clear sequence and drops any staged write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b1;
`ifdef RR_ARB_EN
      rr_q    <= 1'b0;
`else
      starve_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
`ifdef RR_ARB_EN
      rr_q    <= rr_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  assign we     = we_q;
  assign wrAddr = addr_q;
  assign wrData = data_q;
  assign busy   = busy_q;

endmodule
